thermo_modn_counter: RTL and testbench

Parametrised successor to the fixed 4-bit mod-N counter chain. It integrates a clock-enable prescaler, a mod-N counter with four run modes (up, down, ping-pong, hold), synchronous parallel load with clamping, and a registered thermometer-code decoder. It also adds a terminal-count pulse and a direction flag. The block sits between the board clock/switch inputs and the LED bank, and replaces the separate divider/counter/decoder trio.

---
 rtl/thermo_modn_counter.sv | 117 +++++++++++
 tb/tb_thermo_modn_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/thermo_modn_counter.sv
// thermo_modn_counter: prescaled mod-N counter with up/down/ping-pong/hold
// modes, clamped parallel load, terminal-count pulse and a registered
// thermometer-code view of the count.
module thermo_modn_counter #(
   parameter  int N   = 16,
   parameter  int DIV = 50_000_000,
   localparam int CW  = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] in,
   input  logic          load,
   input  logic [1:0]    mode,
   output logic [CW-1:0] count,
   output logic [N-2:0]  thermo_count,
   output logic          tc,
   output logic          dir
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] TOP     = CW'(N - 1);
   localparam logic [CW-1:0] TOP_M1  = CW'(N - 2);
   localparam logic [PW-1:0] PRE_TOP = PW'(DIV - 1);

   localparam logic [1:0] MODE_UP   = 2'b00;
   localparam logic [1:0] MODE_DOWN = 2'b01;
   localparam logic [1:0] MODE_PING = 2'b10;

   logic [PW-1:0]  pre;
   logic           en;
   logic [CW-1:0]  count_next;
   logic           dir_next;
   logic           tc_next;
   logic [N-2:0]   thermo_next;

   // With DIV = 1 pre is pinned at 0, so en is constantly high.
   assign en = (pre == PRE_TOP);

   // Prescaler: free-running 0..DIV-1, unaffected by load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pre <= '0;
      else        pre <= en ? '0 : pre + PW'(1);
   end

   // Next count/dir/tc: load beats an enabled step, which beats holding.
   always_comb begin
      count_next = count;
      dir_next   = dir;
      tc_next    = 1'b0;
      if (load) begin
         // Compare in a wide domain so out-of-range inputs clamp to N-1.
         count_next = (int'(in) > N - 1) ? TOP : in;
      end else if (en) begin
         case (mode)
            MODE_UP: begin
               if (count == TOP) begin
                  count_next = '0;
                  tc_next    = 1'b1;
               end else begin
                  count_next = count + CW'(1);
               end
            end
            MODE_DOWN: begin
               if (count == '0) begin
                  count_next = TOP;
                  tc_next    = 1'b1;
               end else begin
                  count_next = count - CW'(1);
               end
            end
            MODE_PING: begin
               if (!dir) begin
                  if (count == TOP) begin
                     count_next = TOP_M1;
                     dir_next   = 1'b1;
                     tc_next    = 1'b1;
                  end else begin
                     count_next = count + CW'(1);
                  end
               end else begin
                  if (count == '0) begin
                     count_next = CW'(1);
                     dir_next   = 1'b0;
                     tc_next    = 1'b1;
                  end else begin
                     count_next = count - CW'(1);
                  end
               end
            end
            default: ; // hold
         endcase
      end
   end

   // Thermometer decode of the current count, registered below.
   always_comb begin
      thermo_next = '0;
      for (int i = 0; i < N - 1; i++) thermo_next[i] = (i < int'(count));
   end

   // Counter state and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count        <= '0;
         dir          <= 1'b0;
         tc           <= 1'b0;
         thermo_count <= '0;
      end else begin
         count        <= count_next;
         dir          <= dir_next;
         tc           <= tc_next;
         thermo_count <= thermo_next;
      end
   end

endmodule

// File: tb/tb_thermo_modn_counter.sv
// Randomized + directed bench for thermo_modn_counter. Two instances share
// clk/reset: N=10/DIV=4 and N=2/DIV=1. Expectations are queued per edge by a
// reference model and drained by a monitor just after each rising edge.
module tb_thermo_modn_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;

   logic [3:0] in0 = '0;
   logic       load0 = 1'b0;
   logic [1:0] mode0 = 2'b11;
   logic [3:0] count0;
   logic [8:0] th0;
   logic       tc0, dir0;

   logic [0:0] in1 = '0;
   logic       load1 = 1'b0;
   logic [1:0] mode1 = 2'b10;
   logic [0:0] count1;
   logic [0:0] th1;
   logic       tc1, dir1;

   always #5 clk = ~clk;

   thermo_modn_counter #(.N(10), .DIV(4)) dut0 (
      .clk(clk), .reset(reset), .in(in0), .load(load0), .mode(mode0),
      .count(count0), .thermo_count(th0), .tc(tc0), .dir(dir0)
   );

   thermo_modn_counter #(.N(2), .DIV(1)) dut1 (
      .clk(clk), .reset(reset), .in(in1), .load(load1), .mode(mode1),
      .count(count1), .thermo_count(th1), .tc(tc1), .dir(dir1)
   );

   typedef struct {
      int id;
      int count;
      int thermo;
      int tc;
      int dir;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad = 0;

   int nn[2] = '{10, 2};
   int dd[2] = '{4, 1};
   int m_cnt[2];
   int m_pre[2];
   int m_dir[2];

   task automatic chk(string nm, int act, int expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference model: one rising edge for instance id, from the inputs it sees.
   task automatic model_edge(int id, int ld, int inv, int md);
      exp_t e;
      int   n, en, nxt, step;
      n        = nn[id];
      en       = (m_pre[id] == dd[id] - 1);
      e.id     = id;
      e.tc     = 0;
      e.thermo = (1 << m_cnt[id]) - 1;   // thermo reflects the pre-edge count
      m_pre[id] = (m_pre[id] + 1) % dd[id];
      if (ld != 0) begin
         m_cnt[id] = (inv > n - 1) ? n - 1 : inv;
      end else if (en != 0) begin
         case (md)
            0: begin e.tc = (m_cnt[id] == n - 1); m_cnt[id] = (m_cnt[id] + 1) % n; end
            1: begin e.tc = (m_cnt[id] == 0);     m_cnt[id] = (m_cnt[id] + n - 1) % n; end
            2: begin
               // Walk one step; if that leaves 0..n-1, reflect off the end.
               step = (m_dir[id] != 0) ? -1 : 1;
               nxt  = m_cnt[id] + step;
               if (nxt < 0 || nxt > n - 1) begin
                  m_dir[id] = (m_dir[id] != 0) ? 0 : 1;
                  nxt  = m_cnt[id] - step;
                  e.tc = 1;
               end
               m_cnt[id] = nxt;
            end
            default: ;
         endcase
      end
      e.count = m_cnt[id];
      e.dir   = m_dir[id];
      q.push_back(e);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0;
         m_pre[k] = 0;
         m_dir[k] = 0;
      end
   endtask

   // Drive inputs for the coming edge and queue what both DUTs should show.
   task automatic apply(int l0, int i0, int m0, int l1, int i1, int m1);
      load0 = l0[0]; in0 = i0[3:0]; mode0 = m0[1:0];
      load1 = l1[0]; in1 = i1[0:0]; mode1 = m1[1:0];
      model_edge(0, l0, i0, m0);
      model_edge(1, l1, i1, m1);
   endtask

   task automatic step(int l0, int i0, int m0, int l1, int i1, int m1);
      @(negedge clk);
      apply(l0, i0, m0, l1, i1, m1);
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_count0"}, int'(count0), 0);
      chk({tag, "_thermo0"}, int'(th0), 0);
      chk({tag, "_tc0"}, int'(tc0), 0);
      chk({tag, "_dir0"}, int'(dir0), 0);
      chk({tag, "_count1"}, int'(count1), 0);
      chk({tag, "_thermo1"}, int'(th1), 0);
      chk({tag, "_tc1"}, int'(tc1), 0);
      chk({tag, "_dir1"}, int'(dir1), 0);
   endtask

   // Monitor: every registered output is presented each edge; drain and compare.
   always @(posedge clk) begin
      #1;
      while (q.size() > 0) begin
         mon_e = q.pop_front();
         if (mon_e.id == 0) begin
            chk("n10_count", int'(count0), mon_e.count);
            chk("n10_thermo", int'(th0), mon_e.thermo);
            chk("n10_tc", int'(tc0), mon_e.tc);
            chk("n10_dir", int'(dir0), mon_e.dir);
         end else begin
            chk("n2_count", int'(count1), mon_e.count);
            chk("n2_thermo", int'(th1), mon_e.thermo);
            chk("n2_tc", int'(tc1), mon_e.tc);
            chk("n2_dir", int'(dir1), mon_e.dir);
         end
      end
   end

   initial begin
      int guard;
      model_reset();
      #1;
      chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      apply(0, 0, 0, 0, 0, 2);

      // Up-count through a wrap.
      repeat (44) step(0, 0, 0, 0, 0, 2);

      // Down-count from 0.
      step(1, 0, 1, 0, 0, 2);
      repeat (44) step(0, 0, 1, 0, 0, 2);

      // Ping-pong from 0 across both bounces.
      step(1, 0, 2, 0, 0, 2);
      repeat (80) step(0, 0, 2, 0, 0, 2);

      // Clamped load while en is low.
      guard = 0;
      while (m_pre[0] != 1 && guard < 10) begin step(0, 0, 3, 0, 0, 2); guard++; end
      step(1, 13, 3, 0, 0, 2);
      step(0, 0, 3, 0, 0, 2);

      // Load coincident with en: step dropped.
      guard = 0;
      while (m_pre[0] != 3 && guard < 10) begin step(0, 0, 0, 0, 0, 2); guard++; end
      step(1, 3, 0, 0, 0, 2);
      repeat (3) step(0, 0, 0, 0, 0, 2);

      // Get dir = 1 stored, then hold at 5, then resume ping-pong.
      guard = 0;
      while (m_dir[0] != 1 && guard < 100) begin step(0, 0, 2, 0, 0, 2); guard++; end
      chk("reach_dir1", m_dir[0], 1);
      step(1, 5, 3, 0, 0, 2);
      repeat (20) step(0, 0, 3, 0, 0, 2);
      repeat (8) step(0, 0, 2, 0, 0, 2);

      // Randomized modes, loads and load values.
      for (int r = 0; r < 600; r++) begin
         step(($urandom_range(0, 7) == 0) ? 1 : 0, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0) ? 1 : 0, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));
      end

      // Asynchronous reset mid-run at count 7.
      step(1, 0, 0, 1, 0, 2);
      guard = 0;
      while (m_cnt[0] != 7 && guard < 100) begin step(0, 0, 0, 0, 0, 2); guard++; end
      chk("reach_count7", m_cnt[0], 7);
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk_reset_outputs("async");
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      apply(0, 0, 0, 0, 0, 2);

      // First en DIV cycles after release; N=2 ping-pong bounces every cycle.
      repeat (24) step(0, 0, 0, 0, 0, 2);

      @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
